// File: rtl/fun_pkg.sv
// fun_pkg: shared widths, reset table, sweep states and truth-table lookup
package fun_pkg;
  localparam int TT_W = 8;
  localparam int IDX_W = 3;
  localparam logic [TT_W-1:0] TT_DEFAULT = 8'hE2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_e;
  function automatic logic tt_eval(input logic [TT_W-1:0] tt, input logic [IDX_W-1:0] idx);
    return tt[idx];
  endfunction
endpackage

// File: rtl/fun_unit_if.sv
// fun_unit_if: function inputs/outputs, table write and sweep control bundle
interface fun_unit_if;
  import fun_pkg::*;
  logic a, b, c, f;
  logic in_valid, f_q, f_valid;
  logic tt_we;
  logic [TT_W-1:0] tt_wdata, tt;
  logic [3:0] ones_count;
  logic sweep_start, sweep_busy, sweep_done;
  logic [TT_W-1:0] sweep_tt;
  modport master (
    output a, b, c, in_valid, tt_we, tt_wdata, sweep_start,
    input f, f_q, f_valid, tt, ones_count, sweep_busy, sweep_done, sweep_tt
  );
  modport slave (
    input a, b, c, in_valid, tt_we, tt_wdata, sweep_start,
    output f, f_q, f_valid, tt, ones_count, sweep_busy, sweep_done, sweep_tt
  );
endinterface

// File: rtl/fun_sweep.sv
// fun_sweep: walks all eight minterms of the live table, capturing one bit per cycle
module fun_sweep
  import fun_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [TT_W-1:0] i_tt,
  output logic            o_busy,
  output logic            o_done,
  output logic [TT_W-1:0] o_sweep_tt
);
  sweep_state_e     r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TT_W-1:0]  r_sweep_tt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_sweep_tt <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_state    <= RUN;
      r_idx      <= '0;
      r_sweep_tt <= '0;
    end else if (r_state == RUN) begin
      r_sweep_tt[r_idx] <= tt_eval(i_tt, r_idx);
      r_idx             <= r_idx + 3'd1;
      if (r_idx == 3'd7) r_state <= DONE;
    end else if (r_state == DONE) begin
      r_state <= IDLE;
    end
  end
  assign o_busy     = (r_state == RUN);
  assign o_done     = (r_state == DONE);
  assign o_sweep_tt = r_sweep_tt;
endmodule

// File: rtl/fun_unit.sv
// fun_unit: programmable three-input Boolean function with registered path and self-sweep
module fun_unit
  import fun_pkg::*;
#(
  parameter logic [TT_W-1:0] TT_RESET = TT_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  fun_unit_if.slave bus
);
  logic [TT_W-1:0] r_tt;
  logic            r_f_q, r_f_valid;
  logic            w_busy, w_done;
  logic [TT_W-1:0] w_sweep_tt;
  logic [3:0]      w_ones;
  logic            w_f;
  assign w_f = tt_eval(r_tt, {bus.a, bus.b, bus.c});
  // f_q samples the pre-write table, so a same-edge write never leaks into it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt      <= TT_RESET;
      r_f_q     <= 1'b0;
      r_f_valid <= 1'b0;
    end else begin
      if (bus.tt_we && !w_busy) r_tt <= bus.tt_wdata;
      if (bus.in_valid) r_f_q <= w_f;
      r_f_valid <= bus.in_valid;
    end
  end
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < TT_W; i++) w_ones = w_ones + {3'b0, r_tt[i]};
  end
  fun_sweep u_sweep (
    .clk        (clk),
    .rst        (rst),
    .i_start    (bus.sweep_start),
    .i_tt       (r_tt),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_sweep_tt (w_sweep_tt)
  );
  assign bus.f          = w_f;
  assign bus.f_q        = r_f_q;
  assign bus.f_valid    = r_f_valid;
  assign bus.tt         = r_tt;
  assign bus.ones_count = w_ones;
  assign bus.sweep_busy = w_busy;
  assign bus.sweep_done = w_done;
  assign bus.sweep_tt   = w_sweep_tt;
endmodule

// File: tb/tb_fun_unit.sv
// tb_fun_unit: directed and random stimulus checked against a cycle-level behavioural model
module tb_fun_unit;
  import fun_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fun_unit_if bus ();
  fun_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pop(input logic [7:0] v);
    logic [7:0] n = 0;
    for (int i = 0; i < 8; i++) n += {7'b0, v[i]};
    return n;
  endfunction

  // model: m_j counts edges since the accepted sweep_start (-1 = never started)
  logic [7:0] m_tt = TT_DEFAULT, m_stt = 0, tt_old;
  logic m_fq = 0, m_fv = 0, m_init = 0, m_idle, m_busy;
  int m_j = -1;
  always @(posedge clk) begin
    if (rst) begin
      m_tt = TT_DEFAULT; m_stt = 0; m_fq = 0; m_fv = 0; m_j = -1; m_init = 1;
    end else begin
      tt_old = m_tt;
      m_idle = (m_j < 0) || (m_j >= 9);
      m_busy = (m_j >= 0) && (m_j <= 7);
      if (m_busy) m_stt = m_stt | (tt_old & (8'd1 << m_j));
      if (m_j >= 0 && m_j < 9) m_j++;
      if (m_idle && bus.sweep_start) begin m_j = 0; m_stt = 0; end
      if (bus.in_valid) m_fq = tt_old[{bus.a, bus.b, bus.c}];
      m_fv = bus.in_valid;
      if (bus.tt_we && !m_busy) m_tt = bus.tt_wdata;
    end
    #1;
    if (m_init) begin
      chk("f", {7'b0, bus.f}, {7'b0, m_tt[{bus.a, bus.b, bus.c}]});
      chk("f_q", {7'b0, bus.f_q}, {7'b0, m_fq});
      chk("f_valid", {7'b0, bus.f_valid}, {7'b0, m_fv});
      chk("tt", bus.tt, m_tt);
      chk("ones_count", {4'b0, bus.ones_count}, pop(m_tt));
      chk("sweep_busy", {7'b0, bus.sweep_busy}, {7'b0, (m_j >= 0 && m_j <= 7)});
      chk("sweep_done", {7'b0, bus.sweep_done}, {7'b0, (m_j == 8)});
      chk("sweep_tt", bus.sweep_tt, m_stt);
    end
  end

  task automatic drive(input logic [2:0] abc, input logic iv, input logic we,
                       input logic [7:0] wd, input logic ss);
    @(negedge clk);
    {bus.a, bus.b, bus.c} = abc;
    bus.in_valid = iv; bus.tt_we = we; bus.tt_wdata = wd; bus.sweep_start = ss;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    {bus.a, bus.b, bus.c} = 3'b0;
    bus.in_valid = 0; bus.tt_we = 0; bus.tt_wdata = 0; bus.sweep_start = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic run_sweep(input logic interfere, input logic [7:0] exp_tt);
    int nb = 0;
    logic seen = 0;
    drive(3'b0, 0, 0, 8'h0, 1);
    @(negedge clk);
    bus.sweep_start = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.sweep_busy) nb++;
      if (bus.sweep_done) seen = 1;
      else begin
        bus.sweep_start = interfere && (k == 2);
        bus.tt_we = interfere && (k == 2);
        bus.tt_wdata = 8'h00;
        @(negedge clk);
      end
    end
    chk("sweep_done_seen", {7'b0, seen}, 8'd1);
    chk("sweep_busy_cycles", nb[7:0], 8'd8);
    chk("sweep_tt_lit", bus.sweep_tt, exp_tt);
    @(negedge clk);
    chk("done_one_cycle", {7'b0, bus.sweep_done}, 8'd0);
  endtask

  logic [7:0] exp_f = 8'b11100010;
  logic [7:0] x;
  initial begin
    bus.a = 0; bus.b = 0; bus.c = 0; bus.in_valid = 0;
    bus.tt_we = 0; bus.tt_wdata = 0; bus.sweep_start = 0;
    do_reset();
    #1;
    chk("rst_tt", bus.tt, 8'hE2);
    chk("rst_f_valid", {7'b0, bus.f_valid}, 8'd0);
    chk("rst_sweep_tt", bus.sweep_tt, 8'd0);
    for (int i = 0; i < 8; i++) begin
      drive(i[2:0], 1, 0, 8'h0, 0);
      #1;
      chk("f_lit", {7'b0, bus.f}, {7'b0, exp_f[i]});
      chk("ones_lit", {4'b0, bus.ones_count}, 8'd4);
    end
    drive(3'b001, 1, 1, 8'h96, 0);
    @(negedge clk);
    chk("same_edge_f_q", {7'b0, bus.f_q}, 8'd1);
    chk("xor_tt", bus.tt, 8'h96);
    drive(3'b011, 0, 0, 8'h0, 0);
    #1 chk("xor_011", {7'b0, bus.f}, 8'd0);
    drive(3'b111, 0, 0, 8'h0, 0);
    #1 chk("xor_111", {7'b0, bus.f}, 8'd1);
    chk("xor_ones", {4'b0, bus.ones_count}, 8'd4);
    do_reset();
    run_sweep(0, 8'hE2);
    drive(3'b0, 0, 1, 8'hFF, 0);
    run_sweep(1, 8'hFF);
    chk("tt_kept", bus.tt, 8'hFF);
    chk("ones_ff", {4'b0, bus.ones_count}, 8'd8);
    drive(3'b0, 0, 0, 8'h0, 1);
    repeat (5) drive(3'b0, 0, 0, 8'h0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_busy", {7'b0, bus.sweep_busy}, 8'd0);
    chk("abort_sweep_tt", bus.sweep_tt, 8'd0);
    chk("abort_tt", bus.tt, 8'hE2);
    chk("abort_f_valid", {7'b0, bus.f_valid}, 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {7'b0, bus.sweep_done}, 8'd0);
    end
    drive(3'b110, 1, 0, 8'h0, 0);
    repeat (3) begin
      drive(3'b000, 0, 0, 8'h0, 0);
      #1;
      chk("hold_f_q", {7'b0, bus.f_q}, 8'd1);
    end
    chk("hold_f_valid", {7'b0, bus.f_valid}, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      x = 8'($urandom);
      drive(x[2:0], x[3], ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
